// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// One op per 34 cycles: START edge, 32 iterations, FINISH.
module muldiv_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  select_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic [31:0] result_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] opb_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic        neg_q;
  logic        neg_d;
  logic [5:0]  cnt_q;
  logic [31:0] result_q;
  logic [31:0] result_d;
  logic        busy_q;
  logic        done_q;

  logic        is_m;
  logic        sgn_a;
  logic        sgn_b;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign is_m = (select_i[4:3] == 2'b01);

  always_comb begin
    sgn_a = 1'b1;
    sgn_b = 1'b1;
    unique case (select_i[2:0])
      3'b010:  sgn_b = 1'b0;
      3'b011,
      3'b101,
      3'b111: begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
      end
      default: ;
    endcase
  end

  assign neg_a = sgn_a & data1_i[31];
  assign neg_b = sgn_b & data2_i[31];
  assign mag_a = neg_a ? (32'd0 - data1_i) : data1_i;
  assign mag_b = neg_b ? (32'd0 - data2_i) : data2_i;

  // Zero divisor keeps the all-ones quotient unnegated.
  always_comb begin
    if (!select_i[2])
      neg_d = neg_a ^ neg_b;
    else if (select_i[1])
      neg_d = neg_a;
    else
      neg_d = (neg_a ^ neg_b) & (data2_i != 32'd0);
  end

  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_rem;

  assign mul_sum   = {1'b0, acc_q[63:32]}
                   + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_ge    = (div_shift >= {1'b0, opb_q});
  assign div_rem   = div_shift[31:0] - opb_q;

  // acc holds {partial product} or {remainder, quotient}.
  always_comb begin
    if (!op_q[2])
      acc_d = {mul_sum, acc_q[31:1]};
    else if (div_ge)
      acc_d = {div_rem, acc_q[30:0], 1'b1};
    else
      acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
  end

  logic [63:0] prod_n;
  logic [31:0] hi_n;
  logic [31:0] lo_n;

  assign prod_n = neg_q ? (64'd0 - acc_q) : acc_q;
  assign hi_n   = neg_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  assign lo_n   = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];

  always_comb begin
    if (!op_q[2])
      result_d = (op_q[1:0] == 2'b00) ? prod_n[31:0]
                                      : prod_n[63:32];
    else if (op_q[1])
      result_d = hi_n;
    else
      result_d = lo_n;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= 3'd0;
      opb_q    <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      cnt_q    <= 6'd0;
      result_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i && is_m) begin
            op_q    <= select_i[2:0];
            acc_q   <= {32'd0, select_i[2] ? mag_a : mag_b};
            opb_q   <= select_i[2] ? mag_b : mag_a;
            neg_q   <= neg_d;
            cnt_q   <= 6'd0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31)
            state_q <= FINISH;
        end
        FINISH: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_o = result_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule
